arch_state_dump: RTL and testbench

- Hardware reader of the datapath's architectural state (register file and data memory).
- On a start request it walks every register, then every memory word, through the datapath's synchronous debug read port.
- Each word goes out on a valid/ready stream, tagged with its source and index.
- Replaces the bench's wide per-word state outputs with one narrow stream for on-chip checkers or a UART dumper.

---
 rtl/arch_state_dump_pkg.sv | 24 ++
 rtl/arch_state_dump.sv | 138 +++++++++++++
 tb/tb_arch_state_dump.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arch_state_dump_pkg.sv
// Shared definitions for the architectural state dumper.
//
// Contents:
//   state_e       - dump sequencer states
//   SEL_REG/MEM   - debug source select values (also the tag MSB)
//   TAG_SEL_W     - tag layout: out_tag = {sel, idx}, sel in the MSB,
//                   index in the low IDX_W bits
package arch_state_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        SEND,
        DONE
    } state_e;

    localparam logic SEL_REG = 1'b0;
    localparam logic SEL_MEM = 1'b1;

    // Number of source-select bits prepended to the index in a tag.
    localparam int TAG_SEL_W = 1;

endpackage

// File: rtl/arch_state_dump.sv
// Architectural state dumper.
//
// Walks the register file and then the data memory through the datapath's
// synchronous debug read port and emits each word on a valid/ready stream,
// tagged with {sel, index}.
//
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-low reset
//   start           - dump request, honoured only in IDLE
//   en_regs, en_mem - select which arrays to dump, sampled with start
//   busy, done      - busy during the walk, one-cycle done pulse at the end
//   dbg_rd_en/sel/addr, dbg_rdata
//                   - debug read port; data returns one cycle after rd_en
//   out_valid/ready/data/tag/last
//                   - output stream; last marks the final word
module arch_state_dump
    import arch_state_dump_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int IDX_W    = 5,
    parameter int NUM_REGS = 32,
    parameter int NUM_MEM  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       en_regs,
    input  logic                       en_mem,
    output logic                       busy,
    output logic                       done,
    output logic                       dbg_rd_en,
    output logic                       dbg_sel,
    output logic [IDX_W-1:0]           dbg_addr,
    input  logic [DATA_W-1:0]          dbg_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [IDX_W+TAG_SEL_W-1:0] out_tag,
    output logic                       out_last
);

    localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(NUM_MEM - 1);

    state_e                       state_q;
    logic                         enMem_q;
    logic                         sel_q;
    logic [IDX_W-1:0]             idx_q;
    logic [DATA_W-1:0]            outData_q;
    logic [IDX_W+TAG_SEL_W-1:0]   outTag_q;
    logic                         outLast_q;

    logic                         sel_d;
    logic [IDX_W-1:0]             idx_d;
    logic                         isLast;

    // Next position in the walk and whether the current one is the final
    // word. The register file rolls over into memory only when memory is
    // part of the dump; otherwise the last register ends it.
    always_comb begin
        sel_d  = sel_q;
        idx_d  = idx_q + 1'b1;
        if (sel_q == SEL_REG && idx_q == LAST_REG) begin
            sel_d = SEL_MEM;
            idx_d = '0;
        end
        isLast = (sel_q == SEL_MEM && idx_q == LAST_MEM) ||
                 (sel_q == SEL_REG && idx_q == LAST_REG && !enMem_q);
    end

    // Dump sequencer: one debug read per word, captured the following
    // cycle and held on the stream until the consumer takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            enMem_q   <= 1'b0;
            sel_q     <= SEL_REG;
            idx_q     <= '0;
            outData_q <= '0;
            outTag_q  <= '0;
            outLast_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        enMem_q <= en_mem;
                        if (!en_regs && !en_mem) begin
                            state_q <= DONE;
                        end else begin
                            sel_q   <= en_regs ? SEL_REG : SEL_MEM;
                            idx_q   <= '0;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    outData_q <= dbg_rdata;
                    outTag_q  <= {sel_q, idx_q};
                    outLast_q <= isLast;
                    state_q   <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        if (outLast_q) begin
                            state_q <= DONE;
                        end else begin
                            sel_q   <= sel_d;
                            idx_q   <= idx_d;
                            state_q <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Control outputs decode the state register directly, so they drop the
    // instant reset is asserted.
    assign busy      = (state_q == ISSUE) || (state_q == CAPTURE) || (state_q == SEND);
    assign done      = (state_q == DONE);
    assign dbg_rd_en = (state_q == ISSUE);
    assign dbg_sel   = sel_q;
    assign dbg_addr  = idx_q;
    assign out_valid = (state_q == SEND);
    assign out_data  = outData_q;
    assign out_tag   = outTag_q;
    assign out_last  = outLast_q;

endmodule

// File: tb/tb_arch_state_dump.sv
// Self-checking bench for arch_state_dump: a small datapath model answers
// debug reads, expected words are queued when a dump is requested and
// compared as the stream hands them over.
module tb_arch_state_dump;

    localparam int DATA_W   = 32;
    localparam int IDX_W    = 5;
    localparam int NUM_REGS = 32;
    localparam int NUM_MEM  = 32;

    localparam int MODE_PLAIN = 0;
    localparam int MODE_STALL = 1;
    localparam int MODE_RESET = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              en_regs;
    logic              en_mem;
    logic              busy;
    logic              done;
    logic              dbg_rd_en;
    logic              dbg_sel;
    logic [IDX_W-1:0]  dbg_addr;
    logic [DATA_W-1:0] dbg_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W:0]    out_tag;
    logic              out_last;

    typedef struct packed {
        logic [IDX_W:0]    tag;
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    exp_t expQ[$];

    int totalChecks = 0;
    int badChecks   = 0;
    int cycleCount  = 0;
    int wordCount, doneCount, busyCount, memReads;
    int firstValidCycle, hsTag5Cycle, validTag6Cycle;

    logic [DATA_W-1:0] regFile [NUM_REGS];
    logic [DATA_W-1:0] memArr  [NUM_MEM];

    arch_state_dump #(
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W),
        .NUM_REGS (NUM_REGS),
        .NUM_MEM  (NUM_MEM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .en_regs   (en_regs),
        .en_mem    (en_mem),
        .busy      (busy),
        .done      (done),
        .dbg_rd_en (dbg_rd_en),
        .dbg_sel   (dbg_sel),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    // Datapath stand-in: preloaded arrays behind a one-cycle debug read.
    initial begin
        dbg_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) regFile[i] = DATA_W'(i * 3);
        for (int j = 0; j < NUM_MEM; j++)  memArr[j]  = DATA_W'(100 + j);
    end

    always @(posedge clk) begin
        if (dbg_rd_en) dbg_rdata <= dbg_sel ? memArr[dbg_addr] : regFile[dbg_addr];
    end

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, observed, expected);
        end
    endtask

    // Stream monitor: every accepted word is checked against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (done) doneCount++;
            if (busy) busyCount++;
            if (dbg_rd_en && dbg_sel) memReads++;
            if (out_valid) begin
                if (firstValidCycle < 0) firstValidCycle = cycleCount;
                if (out_tag == 6'h06 && validTag6Cycle < 0) validTag6Cycle = cycleCount;
            end
            if (out_valid && out_ready) begin
                wordCount++;
                if (out_tag == 6'h05) hsTag5Cycle = cycleCount;
                if (expQ.size() == 0) begin
                    checkOutput("extra word", 64'(out_tag), 64'h3ff);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("word tag",  64'(out_tag),  64'(e.tag));
                    checkOutput("word data", 64'(out_data), 64'(e.data));
                    checkOutput("word last", 64'(out_last), 64'(e.last));
                end
            end
        end
    end

    task automatic resetCounters();
        wordCount       = 0;
        doneCount       = 0;
        busyCount       = 0;
        memReads        = 0;
        firstValidCycle = -1;
        hsTag5Cycle     = -1;
        validTag6Cycle  = -1;
    endtask

    // Queue the expected words and pulse start; returns the accepting edge.
    task automatic applyStimulus(input logic enR, input logic enM, output int acceptCycle);
        exp_t e;
        if (enR) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                e.tag  = {1'b0, IDX_W'(i)};
                e.data = DATA_W'(i * 3);
                e.last = !enM && (i == NUM_REGS - 1);
                expQ.push_back(e);
            end
        end
        if (enM) begin
            for (int j = 0; j < NUM_MEM; j++) begin
                e.tag  = {1'b1, IDX_W'(j)};
                e.data = DATA_W'(100 + j);
                e.last = (j == NUM_MEM - 1);
                expQ.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        en_regs = enR;
        en_mem  = enM;
        start   = 1'b1;
        @(posedge clk);
        #1;
        acceptCycle = cycleCount;
        start = 1'b0;
    endtask

    // Runs clock cycles until done is seen, optionally stalling the stream,
    // re-pulsing start or asserting reset mid-dump.
    task automatic waitDone(input int maxCycles, input int mode,
                            output bit sawDone, output int doneCycle);
        bit stalled = 0;
        bit pulsed  = 0;
        sawDone   = 0;
        doneCycle = -1;
        for (int c = 0; c < maxCycles; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                sawDone   = 1;
                doneCycle = cycleCount;
                break;
            end
            if (mode == MODE_RESET && out_valid && out_tag == 6'h10) begin
                rst = 1'b0;
                #1;
                checkOutput("reset valid", 64'(out_valid), 64'd0);
                checkOutput("reset busy",  64'(busy),      64'd0);
                checkOutput("reset rd_en", 64'(dbg_rd_en), 64'd0);
                expQ.delete();
                break;
            end
            if (mode == MODE_STALL && !pulsed && out_valid && out_tag == 6'h0A) begin
                en_regs = 1'b1;
                en_mem  = 1'b1;
                start   = 1'b1;
                @(posedge clk);
                #1;
                start  = 1'b0;
                pulsed = 1;
            end
            if (mode == MODE_STALL && !stalled && out_valid && out_tag == 6'h05) begin
                out_ready = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    @(posedge clk);
                    #1;
                    checkOutput("stall valid", 64'(out_valid), 64'd1);
                    checkOutput("stall data",  64'(out_data),  64'd15);
                    checkOutput("stall rd_en", 64'(dbg_rd_en), 64'd0);
                end
                out_ready = 1'b1;
                stalled   = 1;
            end
        end
    endtask

    initial begin
        int  acc;
        int  doneAt;
        bit  sawDone;

        rst       = 1'b0;
        start     = 1'b0;
        en_regs   = 1'b0;
        en_mem    = 1'b0;
        out_ready = 1'b1;
        resetCounters();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst busy",  64'(busy),      64'd0);
        checkOutput("rst done",  64'(done),      64'd0);
        checkOutput("rst rd_en", 64'(dbg_rd_en), 64'd0);
        checkOutput("rst valid", 64'(out_valid), 64'd0);
        checkOutput("rst data",  64'(out_data),  64'd0);
        checkOutput("rst tag",   64'(out_tag),   64'd0);
        checkOutput("rst last",  64'(out_last),  64'd0);
        rst = 1'b1;

        // Full dump, registers then memory.
        $display("[TB] full dump");
        resetCounters();
        applyStimulus(1'b1, 1'b1, acc);
        waitDone(400, MODE_PLAIN, sawDone, doneAt);
        checkOutput("full done seen",   64'(sawDone),                 64'd1);
        checkOutput("full done time",   64'(doneAt - acc),            64'd192);
        checkOutput("full first valid", 64'(firstValidCycle - acc),   64'd2);
        @(negedge clk);
        #1;
        checkOutput("full words",       64'(wordCount),               64'd64);
        checkOutput("full queue",       64'(expQ.size()),             64'd0);
        checkOutput("full mem reads",   64'(memReads),                64'd32);
        checkOutput("full done pulses", 64'(doneCount),               64'd1);

        // Registers only.
        $display("[TB] register-only dump");
        resetCounters();
        applyStimulus(1'b1, 1'b0, acc);
        waitDone(200, MODE_PLAIN, sawDone, doneAt);
        checkOutput("regs done seen",  64'(sawDone),      64'd1);
        @(negedge clk);
        #1;
        checkOutput("regs words",      64'(wordCount),    64'd32);
        checkOutput("regs queue",      64'(expQ.size()),  64'd0);
        checkOutput("regs mem reads",  64'(memReads),     64'd0);

        // Nothing enabled: immediate done, no words.
        $display("[TB] empty dump");
        resetCounters();
        applyStimulus(1'b0, 1'b0, acc);
        checkOutput("empty done",      64'(done),         64'd1);
        checkOutput("empty busy",      64'(busy),         64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("empty done low",  64'(done),         64'd0);
        checkOutput("empty busy cnt",  64'(busyCount),    64'd0);
        checkOutput("empty words",     64'(wordCount),    64'd0);
        checkOutput("empty pulses",    64'(doneCount),    64'd1);

        // Backpressure on tag 0x05 plus a stray start while busy.
        $display("[TB] stall and busy start");
        resetCounters();
        applyStimulus(1'b1, 1'b0, acc);
        waitDone(300, MODE_STALL, sawDone, doneAt);
        checkOutput("stall done seen", 64'(sawDone),                      64'd1);
        checkOutput("stall resume",    64'(validTag6Cycle - hsTag5Cycle), 64'd3);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stall words",     64'(wordCount),    64'd32);
        checkOutput("stall queue",     64'(expQ.size()),  64'd0);
        checkOutput("stall pulses",    64'(doneCount),    64'd1);
        checkOutput("stall idle busy", 64'(busy),         64'd0);

        // Reset in the middle of the dump, then a fresh dump from tag 0.
        $display("[TB] reset mid-dump");
        resetCounters();
        applyStimulus(1'b1, 1'b1, acc);
        waitDone(200, MODE_RESET, sawDone, doneAt);
        checkOutput("abort no done",   64'(sawDone),      64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post rst valid",  64'(out_valid),    64'd0);
        checkOutput("post rst busy",   64'(busy),         64'd0);
        resetCounters();
        applyStimulus(1'b1, 1'b0, acc);
        waitDone(200, MODE_PLAIN, sawDone, doneAt);
        checkOutput("redo done seen",  64'(sawDone),      64'd1);
        @(negedge clk);
        #1;
        checkOutput("redo words",      64'(wordCount),    64'd32);
        checkOutput("redo queue",      64'(expQ.size()),  64'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
